cla_result_display: RTL and testbench

- Downstream consumer of the 16-bit CLA stage's Sum/Cout on the Nexys4 DDR board.
- Samples the CLA result once per slow result clock (the 1 Hz divided clock), captured safely into the fast Clk domain.
- Drives the board's 8-digit multiplexed seven-segment display: Sum as 4 hex digits, Cout on a fifth digit.
- Sits beside the CLA at top level, fed by Sum, Cout and the divided clock as a data signal.

---
 rtl/cla_result_display_pkg.sv | 16 +
 rtl/cla_result_display_hex_to_seg7.sv | 11 +
 rtl/cla_result_display.sv | 114 +++++++++++
 tb/tb_cla_result_display.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cla_result_display_pkg.sv
// Shared constants for the CLA result display: digit layout and the
// active-low seven-segment hex table ({g,f,e,d,c,b,a}).
package cla_result_display_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         NUM_DIGITS = 8;
    localparam int         SUM_DIGITS = 4;
    localparam int         COUT_DIGIT = 4;

    // Entry 15 first so HEX_SEG[n] yields the pattern for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/cla_result_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
    import cla_result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/cla_result_display.sv
// Captures the CLA Sum/Cout on each slow result_clk rising edge and scans
// it onto the 8-digit multiplexed seven-segment display.
module cla_result_display
    import cla_result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        Clk,
    input  logic        Rs,
    input  logic        result_clk,
    input  logic [15:0] sum,
    input  logic        cout,
    input  logic        blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        disp_valid
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic             s1, s2, s3;
    logic             tick;
    logic [15:0]      sum_hold;
    logic             cout_hold;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    // result_clk is asynchronous data: two-flop sync plus an edge detector.
    always_ff @(posedge Clk or negedge Rs) begin
        if (!Rs) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= result_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    always_ff @(posedge Clk or negedge Rs) begin
        if (!Rs) begin
            sum_hold   <= 16'h0000;
            cout_hold  <= 1'b0;
            disp_valid <= 1'b0;
        end else if (tick) begin
            sum_hold   <= sum;
            cout_hold  <= cout;
            disp_valid <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rs) begin
        if (!Rs) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // lz_keep[k]: some nibble at or above k is non-zero, so digit k is significant.
    logic [3:0] lz_keep;
    assign lz_keep = {|sum_hold[15:12], |sum_hold[15:8], |sum_hold[15:4], 1'b1};

    logic [3:0] nib;
    logic       digit_on;
    logic       dp_d;
    logic [6:0] dec_seg;

    always_comb begin
        nib      = 4'h0;
        digit_on = 1'b0;
        dp_d     = 1'b1;
        if (idx < 3'(SUM_DIGITS)) begin
            nib      = sum_hold[{idx[1:0], 2'b00} +: 4];
            digit_on = !LZ_BLANK || lz_keep[idx[1:0]];
        end else if (idx == 3'(COUT_DIGIT)) begin
            nib      = {3'b000, cout_hold};
            digit_on = 1'b1;
            dp_d     = 1'b0;
        end
    end

    hex_to_seg7 u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge Clk or negedge Rs) begin
        if (!Rs) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (!disp_valid || blank || !digit_on) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'b1 << idx);
            seg <= dec_seg;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_cla_result_display.sv
// Randomized bench for cla_result_display: two instances (leading-zero
// blanking on/off) compared every cycle against a cycle-count based model.
module tb_cla_result_display;

    localparam int DIV = 4;
    localparam logic [6:0] TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        Clk = 1'b0;
    logic        Rs = 1'b0;
    logic        result_clk = 1'b0;
    logic [15:0] sum = 16'h0000;
    logic        cout = 1'b0;
    logic        blank = 1'b0;

    logic [7:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       dp1, dp0, dv1, dv0;

    cla_result_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut_lz (
        .Clk(Clk), .Rs(Rs), .result_clk(result_clk), .sum(sum), .cout(cout),
        .blank(blank), .an(an1), .seg(seg1), .dp(dp1), .disp_valid(dv1)
    );

    cla_result_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_nz (
        .Clk(Clk), .Rs(Rs), .result_clk(result_clk), .sum(sum), .cout(cout),
        .blank(blank), .an(an0), .seg(seg0), .dp(dp0), .disp_valid(dv0)
    );

    always #5 Clk = ~Clk;

    // Model state: edges since reset release, recent result_clk samples, held result.
    int          n;
    bit [2:0]    hist;
    bit          mvalid;
    logic [15:0] msum;
    bit          mcout;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Expected display for the digit slot in force before the coming edge.
    task automatic expect_out(input bit lz, output logic [7:0] a, output logic [6:0] s,
                              output bit d, output bit seg_chk);
        int dg = (n / DIV) % 8;
        a = 8'hFF; s = 7'h7F; d = 1'b1; seg_chk = 1'b1;
        if (mvalid && !blank) begin
            if (dg < 4) begin
                if (!lz || dg == 0 || (int'(msum) >> (4 * dg)) != 0) begin
                    a = ~(8'h01 << dg);
                    s = TBL[(msum >> (4 * dg)) & 16'hF];
                end else begin
                    seg_chk = 1'b0;
                end
            end else if (dg == 4) begin
                a = 8'hEF;
                s = TBL[mcout];
                d = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [7:0]  ea1, ea0;
        logic [6:0]  es1, es0;
        bit          ed1, ed0, sc1, sc0, cap;
        logic [15:0] s_smp;
        bit          c_smp;
        expect_out(1'b1, ea1, es1, ed1, sc1);
        expect_out(1'b0, ea0, es0, ed0, sc0);
        cap   = hist[1] & ~hist[2];
        s_smp = sum;
        c_smp = cout;
        hist  = {hist[1:0], result_clk};
        @(posedge Clk);
        #1;
        if (cap) begin
            mvalid = 1'b1;
            msum   = s_smp;
            mcout  = c_smp;
        end
        n++;
        chk("an_lz", an1, ea1);
        chk("dp_lz", dp1, ed1);
        chk("valid_lz", dv1, mvalid);
        if (sc1) chk("seg_lz", seg1, es1);
        chk("onehot_lz", ($countones(~an1) <= 1), 1);
        chk("an_nz", an0, ea0);
        chk("dp_nz", dp0, ed0);
        chk("valid_nz", dv0, mvalid);
        if (sc0) chk("seg_nz", seg0, es0);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic model_reset();
        n = 0; hist = 3'b000; mvalid = 1'b0; msum = 16'h0000; mcout = 1'b0;
    endtask

    task automatic capture(input logic [15:0] s, input bit c, input int hi, input int lo);
        sum = s; cout = c; result_clk = 1'b1;
        run(hi);
        result_clk = 1'b0;
        run(lo);
    endtask

    initial begin
        model_reset();
        @(posedge Clk);
        #1;
        chk("rst_an", an1, 8'hFF);
        chk("rst_seg", seg1, 7'h7F);
        chk("rst_dp", dp1, 1'b1);
        chk("rst_valid", dv1, 1'b0);
        Rs = 1'b1;
        run(20);

        // Capture latency: sampled at first edge, visible on the third.
        sum = 16'h1A2F; cout = 1'b1; result_clk = 1'b1;
        step();
        step();
        chk("lat_e1", dv1, 1'b0);
        step();
        chk("lat_e2", dv1, 1'b1);
        run(17);
        sum = 16'h7777;                 // must not be recaptured while held high
        run(40);
        result_clk = 1'b0;
        run(10);

        // Mid-scan asynchronous reset.
        capture(16'hBEEF, 1'b0, 6, 10);
        #2;
        Rs = 1'b0;
        #1;
        chk("mid_rst_an", an1, 8'hFF);
        chk("mid_rst_seg", seg1, 7'h7F);
        chk("mid_rst_dp", dp1, 1'b1);
        chk("mid_rst_valid", dv1, 1'b0);
        @(posedge Clk);
        #1;
        Rs = 1'b1;
        model_reset();
        run(40);

        // Leading zeros on both instances.
        capture(16'h0005, 1'b0, 5, 40);

        // Blank for 10 cycles.
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("blank_an", an1, 8'hFF);
        end
        blank = 1'b0;

        // Capture coinciding with a digit advance.
        capture(16'h0000, 1'b0, 5, 20);
        while ((n + 2) % DIV != DIV - 1) step();
        capture(16'hFFFF, 1'b1, 5, 40);

        // Randomized results, hold times and blanking.
        for (int it = 0; it < 30; it++) begin
            blank = ($urandom_range(0, 3) == 0);
            capture(16'($urandom), 1'($urandom), $urandom_range(3, 20), $urandom_range(3, 40));
        end
        blank = 1'b0;
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
